result_pack_buffer: RTL

Sits between the adder and the memory write port of the calculator datapath. Accepts one `DATA_W`-bit sum at a time, places it in the upper or lower half of a `MEM_WORD_SIZE`-bit word as selected by the controller's buffer-control bit, and queues each completed word in a small FIFO. The FIFO drains to the memory writer over a valid/ready handshake, decoupling adder throughput from write-port stalls.

---
 rtl/result_pack_buffer_if.sv | 29 ++
 rtl/result_pack_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/result_pack_buffer_if.sv
// Handshake bundle for result_pack_buffer: sum intake from the adder and the
// packed-word stream toward the memory writer.
interface result_pack_buffer_if #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
);
  logic                     sum_valid_i;
  logic                     sum_ready_o;
  logic [DATA_W-1:0]        sum_i;
  logic                     carry_i;
  logic                     half_sel_i;
  logic                     flush_i;
  logic                     word_valid_o;
  logic                     word_ready_i;
  logic [MEM_WORD_SIZE-1:0] word_o;
  logic                     word_ovf_o;
  logic [2:0]               fill_level_o;
  logic                     err_dup_o;

  modport master (
    output sum_valid_i, sum_i, carry_i, half_sel_i, flush_i, word_ready_i,
    input  sum_ready_o, word_valid_o, word_o, word_ovf_o, fill_level_o, err_dup_o
  );

  modport slave (
    input  sum_valid_i, sum_i, carry_i, half_sel_i, flush_i, word_ready_i,
    output sum_ready_o, word_valid_o, word_o, word_ovf_o, fill_level_o, err_dup_o
  );
endinterface

// File: rtl/result_pack_buffer.sv
// Packs two adder sums into one memory word and queues words in a small FIFO.
// Optional per-word overflow tracking is enabled by defining RESULT_PACK_OVF_EN.
module result_pack_buffer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int FIFO_DEPTH    = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  result_pack_buffer_if.slave bus
);
  // Storage is sized for the largest legal depth so pointers index it exactly.
  localparam int         MAX_DEPTH = 4;
  localparam logic [1:0] LAST_IDX  = 2'(FIFO_DEPTH - 1);
  localparam logic [2:0] DEPTH_LVL = 3'(FIFO_DEPTH);

  logic [MEM_WORD_SIZE-1:0] asm_reg;
  logic [MEM_WORD_SIZE-1:0] asm_next;
  logic                     lo_f_reg, hi_f_reg;
  logic                     lo_f_next, hi_f_next;
  logic [1:0]               head_reg, tail_reg;
  logic [2:0]               count_reg;
  logic                     err_dup_reg;
  logic [MEM_WORD_SIZE-1:0] entry_word [MAX_DEPTH];

  logic sum_ready, accept, dup, complete, full, flush_act, push, pop;

  assign full      = (count_reg == DEPTH_LVL);
  assign sum_ready = rst_ni && !full;
  assign accept    = bus.sum_valid_i && sum_ready;
  assign dup       = accept && (bus.half_sel_i ? hi_f_reg : lo_f_reg);
  assign complete  = accept && (bus.half_sel_i ? lo_f_reg : hi_f_reg);

  always_comb begin
    asm_next  = asm_reg;
    lo_f_next = lo_f_reg;
    hi_f_next = hi_f_reg;
    if (accept) begin
      if (bus.half_sel_i) begin
        asm_next[MEM_WORD_SIZE-1:DATA_W] = bus.sum_i;
        hi_f_next                        = 1'b1;
      end else begin
        asm_next[DATA_W-1:0] = bus.sum_i;
        lo_f_next            = 1'b1;
      end
    end
  end

  // A flush sees the word after any same-cycle accept, so both paths push one merged word.
  assign flush_act = bus.flush_i && (lo_f_next || hi_f_next) && !full;
  assign push      = complete || flush_act;
  assign pop       = (count_reg != 3'd0) && bus.word_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      asm_reg     <= '0;
      lo_f_reg    <= 1'b0;
      hi_f_reg    <= 1'b0;
      head_reg    <= 2'd0;
      tail_reg    <= 2'd0;
      count_reg   <= 3'd0;
      err_dup_reg <= 1'b0;
    end else begin
      if (push) begin
        asm_reg  <= '0;
        lo_f_reg <= 1'b0;
        hi_f_reg <= 1'b0;
        tail_reg <= (tail_reg == LAST_IDX) ? 2'd0 : tail_reg + 2'd1;
      end else begin
        asm_reg  <= asm_next;
        lo_f_reg <= lo_f_next;
        hi_f_reg <= hi_f_next;
      end
      if (pop) begin
        head_reg <= (head_reg == LAST_IDX) ? 2'd0 : head_reg + 2'd1;
      end
      count_reg <= count_reg + {2'b00, push} - {2'b00, pop};
      if (dup) begin
        err_dup_reg <= 1'b1;
      end
    end
  end

`ifdef RESULT_PACK_OVF_EN
  logic ovf_acc_reg;
  logic ovf_next;
  logic entry_ovf [MAX_DEPTH];

  assign ovf_next = ovf_acc_reg || (accept && bus.carry_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_acc_reg <= 1'b0;
    end else begin
      ovf_acc_reg <= push ? 1'b0 : ovf_next;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DEPTH; gi++) begin : g_entry
      logic [MEM_WORD_SIZE-1:0] word_reg;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          word_reg <= '0;
        end else if (push && (tail_reg == 2'(gi))) begin
          word_reg <= asm_next;
        end
      end
      assign entry_word[gi] = word_reg;

`ifdef RESULT_PACK_OVF_EN
      logic ovf_reg;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          ovf_reg <= 1'b0;
        end else if (push && (tail_reg == 2'(gi))) begin
          ovf_reg <= ovf_next;
        end
      end
      assign entry_ovf[gi] = ovf_reg;
`endif
    end
  endgenerate

  assign bus.sum_ready_o  = sum_ready;
  assign bus.word_valid_o = (count_reg != 3'd0);
  assign bus.word_o       = (count_reg != 3'd0) ? entry_word[head_reg] : '0;
  assign bus.fill_level_o = count_reg;
  assign bus.err_dup_o    = err_dup_reg;

`ifdef RESULT_PACK_OVF_EN
  assign bus.word_ovf_o = (count_reg != 3'd0) && entry_ovf[head_reg];
`else
  logic carry_unused;
  assign carry_unused   = bus.carry_i;
  assign bus.word_ovf_o = 1'b0;
`endif
endmodule
